// File: rtl/mem_bus_arbiter_if.sv
// Master-side TileLink-UL style A/D channel bundle for mem_bus_arbiter.
//   A channel: a_valid/a_ready handshake plus opcode, address, data, mask, source.
//   D channel: d_valid/d_ready handshake plus response data and source ID.
// master modport: the arbiter (drives A, accepts D).
// slave modport : the bus interface / memory side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [ADDR_W-1:0] a_address;
    logic [DATA_W-1:0] a_data;
    logic [3:0]        a_mask;
    logic              a_source;
    logic              d_valid;
    logic              d_ready;
    logic [DATA_W-1:0] d_data;
    logic              d_source;

    modport master (
        output a_valid, a_opcode, a_address, a_data, a_mask, a_source, d_ready,
        input  a_ready, d_valid, d_data, d_source
    );

    modport slave (
        input  a_valid, a_opcode, a_address, a_data, a_mask, a_source, d_ready,
        output a_ready, d_valid, d_data, d_source
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single A/D master channel between instruction fetch (I) and
// the memory-stage data port (D). One transaction outstanding at a time.
// Data has fixed priority; after MAX_DATA_STREAK consecutive contended data
// grants, fetch wins once.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   if_req_* / if_rsp_*     : fetch requester (read only)
//   dm_req_* / dm_rsp_*     : data requester (load/store)
//   bus                     : A/D channel, master side
//   busy                    : transaction in progress (state != IDLE)
//   err_sticky              : a D beat arrived with the wrong source ID
module mem_bus_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              dm_req_valid,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_req_ready,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] dm_rsp_data,
    mem_bus_arbiter_if.master bus,
    output logic              busy,
    output logic              err_sticky
);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [2:0] OP_GET = 3'd4;
    localparam logic [2:0] OP_PUT = 3'd0;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state, next_state;
    logic [STREAK_W-1:0] streak;
    logic                streak_full;
    logic                grant_any, grant_d;
    logic                a_valid_int, d_ready_int;
    logic                src_q, we_q;
    logic [2:0]          opcode_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                beat_ok;

    assign streak_full = (streak == STREAK_W'(MAX_DATA_STREAK));
    assign beat_ok     = d_ready_int && bus.d_valid && (bus.d_source == src_q);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        if_req_ready = 1'b0;
        dm_req_ready = 1'b0;
        grant_any    = 1'b0;
        grant_d      = 1'b0;
        a_valid_int  = 1'b0;
        d_ready_int  = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless fetch is also waiting and the streak is used up.
                if (dm_req_valid && !(if_req_valid && streak_full)) begin
                    grant_any    = 1'b1;
                    grant_d      = 1'b1;
                    dm_req_ready = 1'b1;
                    next_state   = REQ;
                end else if (if_req_valid) begin
                    grant_any    = 1'b1;
                    if_req_ready = 1'b1;
                    next_state   = REQ;
                end
            end
            REQ: begin
                a_valid_int = 1'b1;
                if (bus.a_ready) next_state = RESP;
            end
            RESP: begin
                d_ready_int = 1'b1;
                if (beat_ok) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak       <= '0;
            src_q        <= 1'b0;
            we_q         <= 1'b0;
            opcode_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            dm_rsp_valid <= 1'b0;
            dm_rsp_data  <= '0;
            err_sticky   <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;

            if (grant_any) begin
                src_q    <= grant_d;
                we_q     <= grant_d && dm_we;
                opcode_q <= (grant_d && dm_we) ? OP_PUT : OP_GET;
                addr_q   <= grant_d ? dm_addr : if_addr;
                wdata_q  <= (grant_d && dm_we) ? dm_wdata : '0;
                // Only contended data grants extend the streak.
                if (grant_d && if_req_valid) begin
                    if (!streak_full) streak <= streak + 1'b1;
                end else begin
                    streak <= '0;
                end
            end

            if (d_ready_int && bus.d_valid) begin
                if (bus.d_source == src_q) begin
                    if (src_q) begin
                        dm_rsp_valid <= 1'b1;
                        dm_rsp_data  <= we_q ? '0 : bus.d_data;
                    end else begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= bus.d_data;
                    end
                end else begin
                    err_sticky <= 1'b1;
                end
            end
        end
    end

    assign bus.a_valid   = a_valid_int;
    assign bus.a_opcode  = opcode_q;
    assign bus.a_address = addr_q;
    assign bus.a_data    = wdata_q;
    assign bus.a_mask    = 4'hF;
    assign bus.a_source  = src_q;
    assign bus.d_ready   = d_ready_int;
    assign busy          = (state != IDLE);
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single TileLink-UL style master channel (A request / D response) between the instruction-fetch requester (port I) and the memory-stage data requester (port D). One transaction is outstanding at a time. Data has fixed priority, with a starvation guard for fetch. The block sits between the fetch/memory stages and the master_slave bus interface.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data width
MAX_DATA_STREAK, 4, number of consecutive contended data grants after which fetch wins once

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
if_req_valid  input  1  fetch read request
if_addr  input  ADDR_W  fetch address
if_req_ready  output  1  fetch request accepted this cycle
if_rsp_valid  output  1  fetch response pulse
if_rsp_data  output  DATA_W  fetched instruction
dm_req_valid  input  1  data request
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_req_ready  output  1  data request accepted this cycle
dm_rsp_valid  output  1  data response pulse (load data or store ack)
dm_rsp_data  output  DATA_W  load data; 0 for stores
a_valid  output  1  A-channel valid
a_ready  input  1  A-channel ready from slave
a_opcode  output  3  3'd4 Get (read), 3'd0 PutFullData (write)
a_address  output  ADDR_W  request address
a_data  output  DATA_W  write data; 0 for Get
a_mask  output  4  always 4'hF
a_source  output  1  0 = fetch, 1 = data
d_valid  input  1  D-channel valid
d_ready  output  1  D-channel ready
d_data  input  DATA_W  response data
d_source  input  1  response source ID
busy  output  1  state != IDLE
err_sticky  output  1  set on a source-mismatched D beat; cleared only by reset

Behaviour:
- Reset:
  - State goes to IDLE; the streak counter clears.
  - All registered outputs go to 0: if/dm_rsp_valid, rsp_data, err_sticky, a_* fields.
  - A reset mid-transaction abandons the transaction: a_valid drops on the next edge, and any later D beat is ignored because d_ready = 0 in IDLE.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Arbitrate combinationally.
  - Only one valid: grant it.
  - Both valid: grant D, unless streak == MAX_DATA_STREAK, in which case grant I.
  - Winner's req_ready = 1 this cycle (the loser's stays 0). Latch addr, wdata, we and source; go to REQ.
  - No request: stay in IDLE.
- Streak counter:
  - Increments on a D grant while if_req_valid = 1.
  - Clears on any I grant, or on a D grant while if_req_valid = 0.
  - Saturates at MAX_DATA_STREAK.
- REQ:
  - a_valid = 1; A fields come from the latches and are held stable until a_ready.
  - On a_valid & a_ready, go to RESP.
- RESP:
  - d_ready = 1.
  - On d_valid with d_source == latched source: register rsp_valid = 1 for the owning port on the next cycle, with rsp_data = d_data (0 for stores); go to IDLE.
  - On d_valid with a mismatched source: consume the beat, set err_sticky, stay in RESP.
- Outside RESP, d_ready = 0.
- rsp_valid is a single-cycle pulse. IDLE may accept a new request in the same cycle the previous rsp_valid is high.
- Latency, with zero-wait slave:
  - Accept at cycle N, a_valid at N+1, d_valid at N+2, rsp_valid at N+3.
  - Back-to-back throughput: one transaction per 3 cycles.
- req_ready is asserted only in IDLE, so a requester holding valid across non-IDLE cycles is not accepted twice.
- If a_ready is held low, the block stays in REQ indefinitely with the A fields unchanged (no timeout).

Test Plan:
- Single fetch: if_req_valid = 1, if_addr = 0x40 at cycle 0; slave a_ready = 1, returns d_data = 0x00100093, d_source = 0 at cycle 2 -> if_req_ready = 1 at cycle 0; a_valid = 1, a_opcode = 4, a_address = 0x40, a_source = 0 at cycle 1; if_rsp_valid = 1 with data 0x00100093 at cycle 3; busy low at cycle 3.
- Store: dm_we = 1, dm_addr = 0x100, dm_wdata = 0xDEADBEEF -> a_opcode = 0, a_data = 0xDEADBEEF, a_mask = 0xF, a_source = 1; on the D ack, dm_rsp_valid pulses with dm_rsp_data = 0.
- Contention: both ports valid continuously, MAX_DATA_STREAK = 4 -> grant order D, D, D, D, I, D, D, D, D, I; the loser's req_ready is never asserted in a grant cycle.
- Backpressure: a_ready low for 5 cycles in REQ -> a_valid stays 1 and a_address/a_data are unchanged; the transition to RESP happens only in the cycle a_ready = 1.
- Source mismatch: in RESP for source 1, d_valid with d_source = 0 -> err_sticky = 1, no rsp_valid on either port; a following d_source = 1 beat completes normally.
- Reset mid-operation: assert reset while in RESP -> busy = 0 and a_valid = 0 after the edge; a later d_valid sees d_ready = 0 and produces no rsp_valid.
